// File: rtl/pulse_window_sched.sv
// Frame scheduler: slices time into fixed windows, captures the external pulse count at
// each window end and hands it to the uploader over a valid/ready output register.
module pulse_window_sched #(
    parameter int WIN_CYCLES = 80000,
    parameter int WINDOWS    = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [31:0] ctr_value,
    output logic        ctr_en,
    output logic        ctr_clr,
    output logic [31:0] out_data,
    output logic [7:0]  out_idx,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done,
    output logic        busy,
    output logic [7:0]  overrun_cnt,
    output logic [1:0]  dbg_state
);

    localparam int WCNT_W = $clog2(WIN_CYCLES);
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WIN_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WPRE  = WCNT_W'(WIN_CYCLES - 2);
    localparam logic [7:0]        XLAST = 8'(WINDOWS - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic [7:0]        widx;

    assign dbg_state = state;

    // Handshake: a beat transfers on any edge where out_valid && out_ready; while
    // out_valid is high and out_ready low the data/idx/last fields never change, and a
    // window ending in that condition is dropped and counted in overrun_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wcnt        <= '0;
            widx        <= '0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            frame_done  <= 1'b0;
            ctr_en      <= 1'b0;
            ctr_clr     <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            frame_done <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (stop && state != IDLE) begin
                // Abort: clear the counter on the way out, keep any pending beat.
                state   <= IDLE;
                busy    <= 1'b0;
                ctr_en  <= 1'b0;
                ctr_clr <= 1'b1;
                wcnt    <= '0;
                widx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        ctr_en  <= 1'b0;
                        ctr_clr <= 1'b0;
                        if (start && !stop) begin
                            state       <= PRIME;
                            busy        <= 1'b1;
                            ctr_clr     <= 1'b1;
                            wcnt        <= '0;
                            widx        <= '0;
                            overrun_cnt <= '0;
                        end
                    end
                    PRIME: begin
                        state   <= RUN;
                        ctr_en  <= 1'b1;
                        ctr_clr <= 1'b0;
                        wcnt    <= '0;
                    end
                    RUN: begin
                        // Clear is registered, so it is raised one cycle ahead of the last count cycle.
                        ctr_clr <= (wcnt == WPRE);
                        if (wcnt == WLAST) begin
                            wcnt <= '0;
                            if (!out_valid || out_ready) begin
                                out_data  <= ctr_value;
                                out_idx   <= widx;
                                out_last  <= (widx == XLAST);
                                out_valid <= 1'b1;
                            end else if (overrun_cnt != 8'hFF) begin
                                overrun_cnt <= overrun_cnt + 8'd1;
                            end
                            if (widx == XLAST) begin
                                state      <= DONE;
                                widx       <= '0;
                                ctr_en     <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                widx <= widx + 8'd1;
                            end
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (continuous) begin
                            state   <= PRIME;
                            ctr_clr <= 1'b1;
                            wcnt    <= '0;
                            widx    <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_window_sched.sv
// Directed bench for pulse_window_sched with a small window (10 cycles, 3 windows) and a
// pulse counter that sees one pulse every cycle.
module tb_pulse_window_sched;

    localparam int WIN = 10;
    localparam int NW  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] ctr_value;
    logic        ctr_en;
    logic        ctr_clr;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        frame_done;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    pulse_window_sched #(.WIN_CYCLES(WIN), .WINDOWS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .ctr_value(ctr_value), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
        .busy(busy), .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // external pulse counter: one pulse per cycle, clear wins over a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ctr_value <= '0;
        else if (ctr_clr) ctr_value <= '0;
        else if (ctr_en)  ctr_value <= ctr_value + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse; returns just after the RUN-entry edge
    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("prime_clr", ctr_clr, 1);
        check("prime_busy", busy, 1);
        check("prime_en", ctr_en, 0);
        tick();
        check("run_en", ctr_en, 1);
        check("run_clr", ctr_clr, 0);
    endtask

    task automatic wait_valid(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!out_valid && cnt < max);
    endtask

    task automatic expect_beat(input string tag, input int lat, input int idx, input logic last);
        wait_valid(lat + 5, n);
        check({tag, "_lat"}, n, lat);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, 9);
        check({tag, "_idx"}, out_idx, idx);
        check({tag, "_last"}, out_last, last);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_en", ctr_en, 0);
        check("rst_clr", ctr_clr, 0);
        check("rst_ovr", overrun_cnt, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // single frame, always ready
        start_frame();
        expect_beat("f1w0", WIN, 0, 1'b0);
        check("f1w0_fd", frame_done, 0);
        tick();
        check("f1_drop", out_valid, 0);
        expect_beat("f1w1", WIN - 1, 1, 1'b0);
        expect_beat("f1w2", WIN, 2, 1'b1);
        check("f1_fd", frame_done, 1);
        tick();
        check("f1_fd_off", frame_done, 0);
        check("f1_idle", busy, 0);
        check("f1_valid_off", out_valid, 0);
        tick();
        check("f1_fd_once", frame_done, 0);

        // continuous: DONE goes straight to PRIME
        continuous = 1'b1;
        start_frame();
        expect_beat("c0", WIN, 0, 1'b0);
        expect_beat("c1", WIN, 1, 1'b0);
        expect_beat("c2", WIN, 2, 1'b1);
        check("c_fd", frame_done, 1);
        tick();
        check("c_prime_clr", ctr_clr, 1);
        check("c_prime_busy", busy, 1);
        check("c_prime_fd", frame_done, 0);
        tick();
        check("c_run_en", ctr_en, 1);
        expect_beat("c_next", WIN, 0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        continuous = 1'b0;
        check("c_stop_busy", busy, 0);
        check("c_stop_clr", ctr_clr, 1);

        // back-pressure: idx0 held, idx1 dropped, idx2 delivered
        out_ready = 1'b0;
        start_frame();
        expect_beat("bp0", WIN, 0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_idx", out_idx, 0);
        check("bp_hold_data", out_data, 9);
        check("bp_ovr", overrun_cnt, 1);
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        tick();
        check("bp_accept", out_valid, 0);
        expect_beat("bp2", 4, 2, 1'b1);
        tick();
        check("bp_ovr_keep", overrun_cnt, 1);
        check("bp_idle", busy, 0);

        // stop in the wcnt=9 cycle of window 1
        start_frame();
        check("st_ovr_clr", overrun_cnt, 0);
        expect_beat("st0", WIN, 0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("st_w9_clr", ctr_clr, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("st_busy", busy, 0);
        check("st_clr", ctr_clr, 1);
        check("st_nocap", out_valid, 0);
        check("st_fd", frame_done, 0);
        tick();
        check("st_fd2", frame_done, 0);
        check("st_clr_off", ctr_clr, 0);
        check("st_en", ctr_en, 0);

        // asynchronous reset mid-window with a pending beat
        out_ready = 1'b0;
        start_frame();
        expect_beat("ar0", WIN, 0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_en", ctr_en, 0);
        check("ar_data", out_data, 0);
        check("ar_idx", out_idx, 0);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("ar_stay_idle", busy, 0);
        start_frame();
        expect_beat("ar_new", WIN, 0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // start and stop together in IDLE
        tick();
        start = 1'b1;
        stop = 1'b1;
        tick();
        check("ss_busy", busy, 0);
        check("ss_clr", ctr_clr, 0);
        start = 1'b0;
        stop = 1'b0;
        tick();
        check("ss_busy2", busy, 0);
        check("ss_state", dbg_state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
